// File: rtl/gcommon_pkg.sv
// Shared definitions for the input-conditioning blocks (synchroniser, debouncer).
package gcommon_pkg;

  // Debounce FSM: IDLE while s2 agrees with y, QUAL while a new level is being qualified.
  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } db_state_t;

  // Depth of the metastability synchroniser in front of every raw pin.
  localparam int SYNC_STAGES = 2;

endpackage : gcommon_pkg

// File: rtl/gdebounce_if.sv
// Pin-side bundle of the debouncer: raw input in, clean level and edge strobes out.
interface gdebounce_if;

  logic a;     // raw asynchronous input
  logic y;     // debounced level
  logic rise;  // one-cycle strobe on y 0->1
  logic fall;  // one-cycle strobe on y 1->0

  // Driver of the raw pin / consumer of the clean level.
  modport master (
    output a,
    input  y,
    input  rise,
    input  fall
  );

  // The debouncer itself.
  modport slave (
    input  a,
    output y,
    output rise,
    output fall
  );

endinterface : gdebounce_if

// File: rtl/gsync2.sv
// Two-flop synchroniser bringing an asynchronous pin into the clk domain.
// Reused for other pins, so it carries its own reset value.
module gsync2
  import gcommon_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  // sync_q[0] is the first (possibly metastable) stage s1, the top bit is s2.
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  // Only the last stage is safe to use downstream.
  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : gsync2

// File: rtl/gdebounce.sv
// Debouncer: synchronises a bouncing pin, requires DB_CYCLES consecutive cycles
// at a new level before the clean output follows, and emits rise/fall strobes.
// All outputs are flops; there is no combinational path from the pin.
module gdebounce
  import gcommon_pkg::*;
#(
  parameter int   DB_CYCLES = 4,
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  gdebounce_if.slave  bus
);

  // Count value on which the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s2;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             y_q,     y_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  gsync2 #(
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.a),
    .q_o   (s2)
  );

  // State, counter, clean level and strobes; reset aborts any qualification silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: a return of s2 to y always wins over acceptance, so a
  // bounce on the final qualifying cycle still aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s2 != y_q) begin
          if (DB_CYCLES == 1) begin
            // Single-cycle qualification: the first differing sample is enough.
            y_d    = s2;
            rise_d = s2;
            fall_d = ~s2;
          end else begin
            state_d = QUAL;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      QUAL: begin
        if (s2 == y_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          y_d     = s2;
          rise_d  = s2;
          fall_d  = ~s2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.y    = y_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule : gdebounce
